inst_mem_responder: RTL
=======================

# inst_mem_responder

Responder end of the instruction-fetch memory interface: accepts the fetch stage's `addr`/`en`/`wr` requests and returns `data_out` with a one-cycle `data_valid` pulse. It serves hits from a direct-mapped line store with single-cycle latency. Misses refill a whole line from the backing memory over a beat-based read port. Writes, used for program load, go through to backing memory.

## Interface
- `LINES`, 16, number of direct-mapped lines; power of two.
- `LINE_WORDS`, 4, 32-bit words per line; power of two.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  32  byte address from fetch; `addr[1:0]` ignored.
- `data_in`  in  32  write data.
- `wr`  in  1  write request; qualified by `en`.
- `en`  in  1  request valid; level, held by requester until `data_valid`.
- `inval`  in  1  one-cycle pulse that invalidates all lines.
- `data_valid`  out  1  one-cycle response pulse.
- `data_out`  out  32  read data; 0 on write responses.
- `mem_req`  out  1  line-fill request; level.
- `mem_addr`  out  32  line-aligned fill address or word write address.
- `mem_rvalid`  in  1  fill beat valid.
- `mem_rdata`  in  32  fill beat data.
- `mem_we`  out  1  write request; level.
- `mem_wdata`  out  32  write data to backing memory.
- `mem_wack`  in  1  write accepted; one-cycle pulse.

## Operation
- Address split:
  - offset = `addr[OFF_W+1:2]`, where OFF_W = clog2(LINE_WORDS).
  - index = next IDX_W bits, where IDX_W = clog2(LINES).
  - tag = remaining upper bits.
- States are IDLE, FILL, RESP and WRITE.
- IDLE, request present (`en` high) and `wr` low:
  - Hit (valid and tag match): register the word; `data_valid` is high next cycle; stay in IDLE.
  - Miss: latch the request, drive `mem_req`=1 with `mem_addr` = line base, clear the beat counter, go to FILL.
- FILL:
  - Each `mem_rvalid` writes `mem_rdata` into word[beat] and increments the beat counter.
  - On beat LINE_WORDS-1: write tag, set valid, drop `mem_req`, go to RESP.
- RESP: drive `data_valid`=1 with the latched word, return to IDLE.
- IDLE, request present with `wr` high:
  - Go to WRITE, driving `mem_we`=1, `mem_addr`=`{addr[31:2],2'b00}` and `mem_wdata`=`data_in`.
  - On `mem_wack`: drop `mem_we`; on a line hit, update that word in the line store; drive `data_valid`=1 and `data_out`=0; go to IDLE.
- Write policy is write-through, no-allocate.
- The request address and data are latched at acceptance. Input changes before `data_valid` are ignored.
- `inval` clears all valid bits in the same edge, in any state.
  - If `inval` arrives during FILL, the fill still completes and responds with correct data, but the line is left invalid.
  - If `inval` and a hit lookup occur in the same cycle, the lookup is treated as a miss.
- `mem_rvalid` and `mem_wack` are ignored outside FILL and WRITE respectively.

## Timing
- Reset values:
  - `data_valid`, `mem_req` and `mem_we` = 0.
  - `data_out`, `mem_addr` and `mem_wdata` = 0.
  - All valid bits = 0; state IDLE; beat counter 0.
- Hit latency is 1: accepted at edge N, `data_valid` is high during cycle N..N+1.
- With `en` held high, back-to-back hits give one response per cycle.
- Miss latency is fill beats + 1. `data_valid` is high during the cycle after the edge that captures the last beat.
- Write latency is `mem_wack` arrival + 1 cycle.
- `rst` mid-FILL or mid-WRITE:
  - Outputs return to reset values immediately; the partial line is left invalid.
  - Beats arriving after reset are ignored.
- Beat counter is OFF_W wide and wraps to 0 after the last beat.

## Structure
- Package `rgb_mem_pkg` holds:
  - `imem_state_t` (IDLE, FILL, RESP, WRITE);
  - the default `LINES`/`LINE_WORDS` constants;
  - the OFF_W/IDX_W derivation helpers.
- Sub-module `imem_line_store` holds the tag, valid and data arrays, with:
  - a combinational read port;
  - a word write port;
  - a tag/valid set port;
  - a clear-all port.
- The top level contains the FSM, beat counter and request latches.

## Test plan
- Reset, then `en` with addr 0x2000: `mem_req` is asserted with `mem_addr`=0x2000; supply beats 0xA0–0xA3; `data_valid` pulses one cycle after the last beat with `data_out`=0xA0.
- `en` held across addr 0x2004, 0x2008, 0x200C on consecutive cycles: three consecutive `data_valid` pulses returning 0xA1, 0xA2, 0xA3, with no `mem_req`.
- Read 0x2100 (same index, new tag): refill with 0xB0–0xB3, response 0xB0; then read 0x2000: it misses and `mem_req` is reasserted.
- `wr`=1 at 0x2004 with `data_in`=0xDEADBEEF on a resident line: `mem_we`, `mem_addr`=0x2004 and `mem_wdata`=0xDEADBEEF are held until `mem_wack`; then `data_valid` pulses; a following read of 0x2004 hits and returns 0xDEADBEEF.
- `rst` pulsed after 2 of 4 beats: all outputs go to 0 asynchronously; stray beats are ignored; the next read of 0x2000 misses.
- `inval` during FILL: the response carries correct data; re-reading the same address misses.

Source files
------------

// File: rtl/inst_mem_responder_pkg.sv
// rgb_mem_pkg: shared state encoding, default geometry and field-width helpers for the instruction memory responder.
package rgb_mem_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} imem_state_t;
    localparam int DEF_LINES = 16;
    localparam int DEF_LINE_WORDS = 4;
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction
endpackage

// File: rtl/inst_mem_responder_line_store.sv
// imem_line_store: direct-mapped tag/valid/data arrays with combinational read, word write, tag set and clear-all.
module imem_line_store import rgb_mem_pkg::*; #(
    parameter int LINES = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [idx_w(LINES)-1:0]       rd_idx,
    input  logic [off_w(LINE_WORDS)-1:0]  rd_off,
    output logic [TAG_W-1:0]              rd_tag,
    output logic                          rd_valid,
    output logic [31:0]                   rd_word,
    input  logic                          we,
    input  logic [idx_w(LINES)-1:0]       w_idx,
    input  logic [off_w(LINE_WORDS)-1:0]  w_off,
    input  logic [31:0]                   w_data,
    input  logic                          set_en,
    input  logic [idx_w(LINES)-1:0]       set_idx,
    input  logic [TAG_W-1:0]              set_tag,
    input  logic                          clr
);
    logic [31:0]      data [LINES][LINE_WORDS];
    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;
    assign rd_tag = tags[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_word = data[rd_idx][rd_off];
    always_ff @(posedge clk) begin
        if (we) data[w_idx][w_off] <= w_data;
        if (set_en) tags[set_idx] <= set_tag;
    end
    // clear-all wins over a same-edge set so an invalidate is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid <= '0;
        else if (clr) valid <= '0;
        else if (set_en) valid[set_idx] <= 1'b1;
    end
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: fetch-side responder serving hits from a direct-mapped line store, refilling misses by beats, writing through.
module inst_mem_responder import rgb_mem_pkg::*; #(
    parameter int LINES = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        wr,
    input  logic        en,
    input  logic        inval,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_wack
);
    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    imem_state_t state;
    logic [29:0] req_wa, lk_wa;
    logic [OFF_W-1:0] beat;
    logic [31:0] resp_word, rd_word;
    logic [TAG_W-1:0] rd_tag;
    logic kill, rd_valid, hit, last, st_we, set_en, unused_low;
    assign unused_low = ^addr[1:0];
    assign lk_wa = (state == IDLE) ? addr[31:2] : req_wa;
    assign hit = rd_valid && rd_tag == lk_wa[29:OFF_W+IDX_W] && !inval;
    assign last = &beat;
    assign st_we = (state == FILL && mem_rvalid) || (state == WRITE && mem_wack && hit);
    assign set_en = state == FILL && mem_rvalid && last && !kill;
    imem_line_store #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)) u_store (
        .clk(clk),
        .rst(rst),
        .rd_idx(lk_wa[OFF_W+IDX_W-1:OFF_W]),
        .rd_off(lk_wa[OFF_W-1:0]),
        .rd_tag(rd_tag),
        .rd_valid(rd_valid),
        .rd_word(rd_word),
        .we(st_we),
        .w_idx(req_wa[OFF_W+IDX_W-1:OFF_W]),
        .w_off(state == FILL ? beat : req_wa[OFF_W-1:0]),
        .w_data(state == FILL ? mem_rdata : mem_wdata),
        .set_en(set_en),
        .set_idx(req_wa[OFF_W+IDX_W-1:OFF_W]),
        .set_tag(req_wa[29:OFF_W+IDX_W]),
        .clr(inval)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data_valid <= 1'b0;
            data_out <= '0;
            mem_req <= 1'b0;
            mem_addr <= '0;
            mem_we <= 1'b0;
            mem_wdata <= '0;
            beat <= '0;
            req_wa <= '0;
            resp_word <= '0;
            kill <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    req_wa <= addr[31:2];
                    if (wr) begin
                        state <= WRITE;
                        mem_we <= 1'b1;
                        mem_addr <= {addr[31:2], 2'b00};
                        mem_wdata <= data_in;
                    end else if (hit) begin
                        data_valid <= 1'b1;
                        data_out <= rd_word;
                    end else begin
                        state <= FILL;
                        mem_req <= 1'b1;
                        mem_addr <= {addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                        beat <= '0;
                        kill <= 1'b0;
                    end
                end
                FILL: begin
                    // an invalidate seen mid-fill keeps the refilled line from becoming valid
                    if (inval) kill <= 1'b1;
                    if (mem_rvalid) begin
                        beat <= beat + 1'b1;
                        if (beat == req_wa[OFF_W-1:0]) resp_word <= mem_rdata;
                        if (last) begin
                            mem_req <= 1'b0;
                            data_valid <= 1'b1;
                            data_out <= (beat == req_wa[OFF_W-1:0]) ? mem_rdata : resp_word;
                            state <= RESP;
                        end
                    end
                end
                RESP: state <= IDLE;
                WRITE: if (mem_wack) begin
                    mem_we <= 1'b0;
                    data_valid <= 1'b1;
                    data_out <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
